fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Fetch-stage sequencer for the pipelined 16-bit core.
- Owns the PC register and drives a multi-cycle instruction-memory handshake (req/ack).
- Feeds the IF/ID register and honours hazard stalls, EX-stage branch/jump redirects and HALT.
- Replaces the single-cycle next-PC path; PC+2 and branch-target adders stay in the datapath, and only the resolved target arrives here.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- NOP_INSTR, 16'h0800, instruction presented on if_instr when if_valid=0.
- MAX_WAIT, 8'd255, cycles allowed in WAIT before a memory timeout error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold the IF/ID outputs.
- redirect  in  1  EX resolved a taken branch or jump this cycle.
- redirect_pc  in  16  target PC for redirect.
- halt  in  1  decode saw HALT; stop fetching.
- mem_req  out  1  single-cycle fetch request.
- mem_addr  out  16  fetch address; equals pc.
- mem_ack  in  1  mem_data valid this cycle.
- mem_data  in  16  returned instruction word.
- if_valid  out  1  IF/ID holds a valid instruction.
- if_instr  out  16  IF/ID instruction.
- if_pc_plus2  out  16  PC+2 of if_instr.
- err  out  1  sticky error: timeout, PC overflow or misaligned redirect.

Behaviour:
- Reset (async, rst_n=0) state:
  - pc=RESET_PC, state=REQ, squash=0, wait_cnt=0, buffer empty.
  - if_valid=0, if_instr=NOP_INSTR, if_pc_plus2=0, err=0.
  - mem_req=0 while in reset.
- Reset mid-transaction drops any outstanding ack; the first REQ after release uses RESET_PC.
- States: REQ, WAIT, HOLD, HALTED.
- REQ:
  - mem_req = !redirect & !halt.
  - redirect: pc<=redirect_pc, stay in REQ.
  - halt: go to HALTED.
  - otherwise: go to WAIT, wait_cnt<=0.
- WAIT:
  - redirect without ack: pc<=redirect_pc, squash<=1.
  - mem_ack with (squash | redirect): discard the data, squash<=0, go to REQ; pc is already the redirect target, or is redirect_pc if the redirect is this cycle.
  - mem_ack with stall=0: load the IF/ID outputs with (1, mem_data, pc+2), pc<=pc+2, go to REQ.
  - mem_ack with stall=1: write (mem_data, pc+2) to the one-entry buffer, pc<=pc+2, go to HOLD.
  - no ack: wait_cnt++. When wait_cnt reaches MAX_WAIT: err<=1, go to HALTED.
- HOLD:
  - redirect: flush the buffer, pc<=redirect_pc, go to REQ.
  - stall=0: move the buffer to the IF/ID outputs, go to REQ.
- HALTED:
  - mem_req=0 and no state change until reset.
  - A pending ack is ignored.
  - The IF/ID outputs drain normally.
- IF/ID output register:
  - Updates only when stall=0 or redirect=1.
  - redirect forces if_valid<=0, if_instr<=NOP_INSTR, and has priority over stall.
  - With stall=0 and no new instruction: if_valid<=0, if_instr<=NOP_INSTR.
- Priority within a cycle: reset > redirect > halt > stall > normal.
- A redirect and a halt in the same cycle: the redirect wins and halt is ignored, because the HALT is on the wrong path.
- Width rules:
  - pc+2 wraps modulo 2^16; a wrap from 16'hFFFE sets err, and fetching continues from 0.
  - redirect_pc[0]=1: err<=1, go to HALTED, and the redirect is not applied.
- err is sticky until reset.
- Latency with a 1-cycle ack:
  - mem_req at cycle N, ack at N+1, if_valid at N+2, next mem_req at N+2.
  - Peak rate is one instruction per 2 cycles.

Decomposition:
- Package fetch_pkg holds:
  - the state encoding (REQ=2'd0, WAIT=2'd1, HOLD=2'd2, HALTED=2'd3);
  - NOP_INSTR and RESET_PC defaults;
  - the WAIT counter width (8).
- One sub-module, fetch_skid_buf: a one-entry buffer with load, flush and drain, holding instr and pc_plus2 plus a valid bit.
- The FSM, PC register and IF/ID register stay in fetch_ctrl.

Test Plan:
- Reset then free-run, ack 1 cycle after each req, mem_data=16'hA000+addr:
  - mem_addr sequence is 0, 2, 4.
  - if_valid pulses at cycles 2, 4, 6.
  - if_instr is A000, A002, A004 and if_pc_plus2 is 2, 4, 6.
- Ack delayed 5 cycles with redirect=1, redirect_pc=16'h0040 asserted in the 2nd WAIT cycle:
  - the returned data is discarded and if_valid stays 0;
  - the next mem_req is to 16'h0040.
- stall=1 for 4 cycles spanning an ack:
  - the IF/ID outputs hold their old values;
  - the fetched word is buffered, with no second mem_req during HOLD;
  - the word appears on if_instr the cycle after stall drops.
- halt=1 together with redirect=1, then halt=1 alone:
  - the first cycle redirects;
  - the second goes to HALTED, after which mem_req stays 0 for 20 cycles and err=0.
- mem_ack held low for 256 cycles: err=1 on timeout, the state is HALTED, and rst_n low clears err and restarts at pc=0.
- redirect_pc=16'h0041: err=1, the state is HALTED, and pc is unchanged.
- Starting at pc=16'hFFFE: the fetch delivers, err=1, and the next mem_addr is 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, reset defaults
// for the PC and the bubble instruction, and the WAIT timeout counter width.
package fetch_pkg;

    typedef enum logic [1:0] {
        StReq    = 2'd0,
        StWait   = 2'd1,
        StHold   = 2'd2,
        StHalted = 2'd3
    } fetch_state_e;

    localparam logic [15:0] NopInstrDefault = 16'h0800;
    localparam logic [15:0] ResetPcDefault  = 16'h0000;
    localparam int unsigned WaitCntWidth    = 8;

    // Last aligned PC before pc+2 wraps to zero.
    function automatic logic pc_will_wrap(input logic [15:0] pc);
        return pc == 16'hFFFE;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory handshake between the fetch stage and instruction memory.
//   mem_req  : single-cycle fetch request (fetch -> memory)
//   mem_addr : fetch address (fetch -> memory)
//   mem_ack  : mem_data valid this cycle (memory -> fetch)
//   mem_data : returned instruction word (memory -> fetch)
interface fetch_ctrl_if;

    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word that arrived while decode was
// stalled. Flush has priority over load, load over drain.
//   clk, rst_n   : clock, async active-low reset
//   load_i       : capture instr_i / pc_plus2_i
//   flush_i      : discard the entry
//   drain_i      : entry consumed by the IF/ID register
//   valid_o, instr_o, pc_plus2_o : held entry
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        drain_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pc_plus2_i,
    output logic        valid_o,
    output logic [15:0] instr_o,
    output logic [15:0] pc_plus2_o
);

    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus2_q, pc_plus2_d;

    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_plus2_d = pc_plus2_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d    = 1'b1;
            instr_d    = instr_i;
            pc_plus2_d = pc_plus2_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_plus2_q <= '0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_plus2_o = pc_plus2_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the req/ack instruction-memory
// handshake and feeds the IF/ID register, honouring stalls, EX redirects and HALT.
//   clk, rst_n          : clock, async active-low reset
//   stall               : hold IF/ID outputs
//   redirect/redirect_pc: taken branch/jump resolved in EX
//   halt                : stop fetching
//   mem                 : instruction-memory handshake (master side)
//   if_valid/if_instr/if_pc_plus2 : IF/ID register
//   err                 : sticky timeout / PC wrap / misaligned redirect
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [15:0]             RESET_PC  = ResetPcDefault,
    parameter logic [15:0]             NOP_INSTR = NopInstrDefault,
    parameter logic [WaitCntWidth-1:0] MAX_WAIT  = 8'd255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          redirect,
    input  logic [15:0]   redirect_pc,
    input  logic          halt,
    fetch_ctrl_if.master  mem,
    output logic          if_valid,
    output logic [15:0]   if_instr,
    output logic [15:0]   if_pc_plus2,
    output logic          err
);

    fetch_state_e            state_q, state_d;
    logic [15:0]             pc_q, pc_d;
    logic                    squash_q, squash_d;
    logic [WaitCntWidth-1:0] wait_cnt_q, wait_cnt_d;
    logic                    if_valid_q, if_valid_d;
    logic [15:0]             if_instr_q, if_instr_d;
    logic [15:0]             if_pc_plus2_q, if_pc_plus2_d;
    logic                    err_q, err_d;

    logic [15:0] pc_plus2;
    logic        redir_bad;
    logic        buf_load, buf_flush, buf_drain, buf_valid;
    logic [15:0] buf_instr, buf_pc_plus2;
    logic        new_vld;
    logic [15:0] new_instr, new_pc_plus2;

    assign pc_plus2  = pc_q + 16'd2;
    assign redir_bad = redirect & redirect_pc[0];

    // Request is combinational so a redirect/halt in REQ suppresses it the same cycle.
    assign mem.mem_req  = rst_n & (state_q == StReq) & ~redirect & ~halt;
    assign mem.mem_addr = pc_q;

    fetch_skid_buf u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (buf_load),
        .flush_i   (buf_flush),
        .drain_i   (buf_drain),
        .instr_i   (mem.mem_data),
        .pc_plus2_i(pc_plus2),
        .valid_o   (buf_valid),
        .instr_o   (buf_instr),
        .pc_plus2_o(buf_pc_plus2)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        squash_d     = squash_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
        buf_load     = 1'b0;
        buf_flush    = 1'b0;
        buf_drain    = 1'b0;
        new_vld      = 1'b0;
        new_instr    = mem.mem_data;
        new_pc_plus2 = pc_plus2;

        unique case (state_q)
            StReq: begin
                if (redir_bad) begin
                    err_d   = 1'b1;
                    state_d = StHalted;
                end else if (redirect) begin
                    pc_d = redirect_pc;
                end else if (halt) begin
                    state_d = StHalted;
                end else begin
                    state_d    = StWait;
                    wait_cnt_d = '0;
                end
            end
            StWait: begin
                if (redir_bad) begin
                    err_d    = 1'b1;
                    squash_d = 1'b0;
                    state_d  = StHalted;
                end else if (mem.mem_ack) begin
                    if (squash_q || redirect) begin
                        // Wrong-path word: drop it, pc already holds (or takes) the target.
                        squash_d = 1'b0;
                        if (redirect) pc_d = redirect_pc;
                        state_d = StReq;
                    end else begin
                        pc_d = pc_plus2;
                        if (pc_will_wrap(pc_q)) err_d = 1'b1;
                        if (stall) begin
                            buf_load = 1'b1;
                            state_d  = StHold;
                        end else begin
                            new_vld = 1'b1;
                            state_d = StReq;
                        end
                    end
                end else begin
                    if (redirect) begin
                        pc_d     = redirect_pc;
                        squash_d = 1'b1;
                    end
                    if (wait_cnt_q == MAX_WAIT) begin
                        err_d   = 1'b1;
                        state_d = StHalted;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WaitCntWidth'(1);
                    end
                end
            end
            StHold: begin
                if (redirect) begin
                    buf_flush = 1'b1;
                    if (redir_bad) begin
                        err_d   = 1'b1;
                        state_d = StHalted;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = StReq;
                    end
                end else if (!stall) begin
                    buf_drain    = 1'b1;
                    new_vld      = buf_valid;
                    new_instr    = buf_instr;
                    new_pc_plus2 = buf_pc_plus2;
                    state_d      = StReq;
                end
            end
            StHalted: begin
                // Terminal until reset; late acks are ignored.
            end
        endcase
    end

    // IF/ID register: redirect flushes and beats stall; otherwise it only moves when unstalled.
    always_comb begin
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_plus2_d = if_pc_plus2_q;
        if (redirect) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (new_vld) begin
                if_valid_d    = 1'b1;
                if_instr_d    = new_instr;
                if_pc_plus2_d = new_pc_plus2;
            end else begin
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StReq;
            pc_q          <= RESET_PC;
            squash_q      <= 1'b0;
            wait_cnt_q    <= '0;
            if_valid_q    <= 1'b0;
            if_instr_q    <= NOP_INSTR;
            if_pc_plus2_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            squash_q      <= squash_d;
            wait_cnt_q    <= wait_cnt_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_plus2_q <= if_pc_plus2_d;
            err_q         <= err_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc_plus2 = if_pc_plus2_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by a randomized run checked
// by a scoreboard fed from a transaction-level model of the fetch stream.
module tb_fetch_ctrl;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect, halt;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr, if_pc_plus2;
    logic        err;

    always #5 clk = ~clk;

    fetch_ctrl_if mem_bus ();

    fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .mem        (mem_bus),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc_plus2(if_pc_plus2),
        .err        (err)
    );

    int checks = 0;
    int failures = 0;

    // Memory responder state
    bit          pending, killed, ack_en, rand_delay;
    int          cnt, ack_delay, cyc;
    logic [15:0] pend_addr, pend_exp;

    // Reference model: next expected fetch address and in-order delivered stream
    bit          sb_en;
    logic [15:0] exp_addr;
    exp_t        sb_q[$];
    exp_t        mon_e;
    int          pops;
    bit          stall_last = 1'b1;

    // Per-cycle snapshot taken mid-cycle
    logic        s_req, s_valid, s_err;
    logic [15:0] s_addr, s_instr, s_pc2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample the cycle that is in progress, then set up next-cycle ack.
    task automatic tick();
        bit acked;
        @(negedge clk);
        #1;
        s_req   = mem_bus.mem_req;
        s_addr  = mem_bus.mem_addr;
        s_valid = if_valid;
        s_instr = if_instr;
        s_pc2   = if_pc_plus2;
        s_err   = err;
        acked   = mem_bus.mem_ack;
        if (sb_en) begin
            // A redirect squashes everything fetched but not yet presented on IF/ID.
            if (acked && !killed && !redirect)
                sb_q.push_back({16'hA000 + pend_exp, pend_exp + 16'd2});
            if (redirect) begin
                sb_q.delete();
                exp_addr = redirect_pc;
            end
            if (s_req) begin
                check("req_overlap", 32'(pending && !acked), 32'd0);
                check("req_addr", 32'(s_addr), 32'(exp_addr));
            end
        end
        if (acked) pending = 1'b0;
        if (redirect) killed = 1'b1;
        if (s_req) begin
            pending   = 1'b1;
            killed    = 1'b0;
            pend_addr = s_addr;
            pend_exp  = exp_addr;
            exp_addr  = exp_addr + 16'd2;
            cnt       = rand_delay ? int'($urandom_range(4, 1)) : ack_delay;
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_data = 16'($urandom);
        if (pending && ack_en) begin
            cnt--;
            if (cnt <= 0) begin
                mem_bus.mem_ack  = 1'b1;
                mem_bus.mem_data = 16'hA000 + pend_addr;
            end
        end
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        stall            = 1'b0;
        redirect         = 1'b0;
        halt             = 1'b0;
        redirect_pc      = 16'h0;
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_data = 16'h0;
        pending          = 1'b0;
        killed           = 1'b0;
        exp_addr         = 16'h0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_instr", 32'(if_instr), 32'h0800);
        check("rst_pc2", 32'(if_pc_plus2), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_req", 32'(mem_bus.mem_req), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Scoreboard monitor: a new IF/ID word appears when the previous cycle was unstalled.
    always @(negedge clk) begin
        if (sb_en && if_valid && !stall_last) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got instr %0h pc2 %0h expected none",
                         if_instr, if_pc_plus2);
            end else begin
                mon_e = sb_q.pop_front();
                pops++;
                check("sb_instr", 32'(if_instr), 32'(mon_e.instr));
                check("sb_pc2", 32'(if_pc_plus2), 32'(mon_e.pc2));
            end
        end
        stall_last = sb_en ? stall : 1'b1;
    end

    initial begin
        bit seen_valid, got_req;
        int req_cnt;
        sb_en      = 1'b0;
        ack_en     = 1'b1;
        rand_delay = 1'b0;
        ack_delay  = 1;
        pops       = 0;
        cyc        = 0;

        // Free-run with 1-cycle ack: req 0,2,4,6; IF/ID at 2,4,6
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            tick();
            check("lat_req", 32'(s_req), 32'(c % 2 == 0));
            if (c % 2 == 0 && c <= 4) check("lat_addr", 32'(s_addr), 32'(c));
            check("lat_valid", 32'(s_valid), 32'(c >= 2 && c % 2 == 0));
            if (c >= 2 && c % 2 == 0) begin
                check("lat_instr", 32'(s_instr), 32'h0000A000 + 32'(c - 2));
                check("lat_pc2", 32'(s_pc2), 32'(c));
            end
        end

        // Redirect during WAIT with a 5-cycle ack: data dropped, refetch at 0x40
        do_reset();
        ack_delay  = 5;
        seen_valid = 1'b0;
        got_req    = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            redirect    = (c == 2);
            redirect_pc = 16'h0040;
            tick();
            if (s_valid) seen_valid = 1'b1;
            if (c > 0 && s_req && !got_req) begin
                got_req = 1'b1;
                check("squash_addr", 32'(s_addr), 32'h40);
                check("squash_cycle", 32'(c), 32'd6);
            end
        end
        redirect = 1'b0;
        check("squash_valid", 32'(seen_valid), 32'd0);
        check("squash_refetch", 32'(got_req), 32'd1);

        // Stall across an ack: IF/ID frozen, word buffered, delivered after stall drops
        do_reset();
        ack_delay = 2;
        for (int c = 0; c <= 8; c++) begin
            stall = (c >= 3 && c <= 6);
            tick();
            if (c >= 4 && c <= 7) begin
                check("stall_valid", 32'(s_valid), 32'd1);
                check("stall_instr", 32'(s_instr), 32'hA000);
                check("stall_pc2", 32'(s_pc2), 32'd2);
                check("stall_noreq", 32'(s_req), 32'd0);
            end
            if (c == 8) begin
                check("hold_out_valid", 32'(s_valid), 32'd1);
                check("hold_out_instr", 32'(s_instr), 32'hA002);
                check("hold_out_pc2", 32'(s_pc2), 32'd4);
                check("hold_next_req", 32'(s_req), 32'd1);
                check("hold_next_addr", 32'(s_addr), 32'd4);
            end
        end
        stall = 1'b0;

        // Halt together with redirect: redirect wins; then halt alone stops fetching
        do_reset();
        ack_delay   = 1;
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        halt        = 1'b1;
        tick();
        check("hr_req", 32'(s_req), 32'd0);
        redirect = 1'b0;
        tick();
        check("halt_pc", 32'(s_addr), 32'h20);
        check("halt_req", 32'(s_req), 32'd0);
        halt    = 1'b0;
        req_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (s_req) req_cnt++;
        end
        check("halted_reqs", 32'(req_cnt), 32'd0);
        check("halted_err", 32'(s_err), 32'd0);

        // Memory timeout: no ack for 256 WAIT cycles
        do_reset();
        ack_en  = 1'b0;
        req_cnt = 0;
        for (int c = 0; c <= 262; c++) begin
            tick();
            if (c == 0) check("to_first_addr", 32'(s_addr), 32'd0);
            if (c == 256) check("to_err_before", 32'(s_err), 32'd0);
            if (c == 257) check("to_err", 32'(s_err), 32'd1);
            if (c > 0 && s_req) req_cnt++;
        end
        check("to_reqs", 32'(req_cnt), 32'd0);
        check("to_err_sticky", 32'(s_err), 32'd1);
        ack_en = 1'b1;
        do_reset();
        tick();
        check("to_restart_req", 32'(s_req), 32'd1);
        check("to_restart_addr", 32'(s_addr), 32'd0);

        // Misaligned redirect: error, halted, pc unchanged
        do_reset();
        ack_delay = 1;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        tick();
        check("mis_req", 32'(s_req), 32'd0);
        redirect = 1'b0;
        tick();
        check("mis_err", 32'(s_err), 32'd1);
        check("mis_pc", 32'(s_addr), 32'd2);
        req_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (s_req) req_cnt++;
        end
        check("mis_halted", 32'(req_cnt), 32'd0);

        // PC wrap from 0xFFFE
        do_reset();
        ack_delay   = 1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        tick();
        check("wrap_req_addr", 32'(s_addr), 32'hFFFE);
        tick();
        check("wrap_err_pre", 32'(s_err), 32'd0);
        tick();
        check("wrap_valid", 32'(s_valid), 32'd1);
        check("wrap_instr", 32'(s_instr), 32'h9FFE);
        check("wrap_pc2", 32'(s_pc2), 32'd0);
        check("wrap_err", 32'(s_err), 32'd1);
        check("wrap_next_addr", 32'(s_addr), 32'd0);

        // Randomized run against the scoreboard
        do_reset();
        rand_delay = 1'b1;
        sb_en      = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            stall       = ($urandom_range(3, 0) == 0);
            redirect    = ($urandom_range(15, 0) == 0);
            redirect_pc = {7'd0, 8'($urandom_range(255, 0)), 1'b0};
            tick();
        end
        sb_en    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        check("rand_deliveries", 32'(pops > 100), 32'd1);
        check("rand_err", 32'(s_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
